// File: rtl/boxhead_soc_key_ctrl.sv
// Avalon-MM push-button controller: 2-FF sync, per-key debounce,
// sticky press-edge latch with W1C clear and a maskable level irq.
module boxhead_soc_key_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    COUNT
  } db_state_t;

  db_state_t        state [WIDTH];
  logic [CNT_W-1:0] cnt   [WIDTH];

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] key_edge;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign raw          = ACTIVE_LOW ? ~sync2 : sync2;
  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign unused_wdata = ^writedata[31:WIDTH];

  // A press is accepted on the same edge the debouncer toggles stable 0->1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rise[i] = (state[i] == COUNT) && (cnt[i] == LAST) &&
                (raw[i] != stable[i]) && !stable[i];
    end
  end

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) begin
      clr = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (address)
      2'd0: rd_word[WIDTH-1:0] = stable;
      2'd1: rd_word[WIDTH-1:0] = raw;
      2'd2: rd_word[WIDTH-1:0] = mask;
      2'd3: rd_word[WIDTH-1:0] = key_edge;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (state[i])
          IDLE: begin
            if (raw[i] != stable[i]) begin
              state[i] <= COUNT;
              cnt[i]   <= CNT_W'(1);
            end
          end
          COUNT: begin
            if (raw[i] == stable[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST) begin
              stable[i] <= ~stable[i];
              state[i]  <= IDLE;
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= RELEASED;
      sync2    <= RELEASED;
      mask     <= '0;
      key_edge <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      if (wr_en && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
      // Set beats a simultaneous W1C so a press is never lost.
      key_edge <= (key_edge & ~clr) | rise;
      irq      <= |(key_edge & mask);
      readdata <= rd_en ? rd_word : 32'd0;
    end
  end

endmodule
